dest_mac_filter: RTL and testbench

- Sits directly downstream of the packet buffering stage and consumes its buffered stream together with its per-packet metadata (48-bit destination address, length-minus-one).
- Decides once per packet whether to forward the packet or discard it:
  - Forward: the packet goes to the next stage through a registered output slice.
  - Discard: a one-cycle drop pulse goes back upstream, which flushes the held packet.
- Keeps saturating pass/drop statistics counters.

---
 rtl/filter_pkg.sv | 35 +++
 rtl/stream_reg_slice.sv | 34 +++
 rtl/dest_mac_filter.sv | 137 +++++++++++++
 tb/tb_dest_mac_filter.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
// Shared definitions for the destination-address filter.
//   state_t     : filter control states
//   BCAST_ADDR  : all-ones broadcast address
//   MCAST_BIT   : I/G bit of the first transmitted octet
//   addr_match  : address acceptance rule for one destination address
package filter_pkg;

  typedef enum logic [1:0] {
    IDLE,
    EVAL,
    PASS,
    DROP
  } state_t;

  localparam logic [47:0] BCAST_ADDR = 48'hFFFF_FFFF_FFFF;
  localparam int unsigned MCAST_BIT  = 40;

  // Broadcast is excluded from the multicast rule so that accept_bcast alone
  // decides whether broadcast traffic is taken.
  function automatic logic addr_match(
    input logic [47:0] dest,
    input logic [47:0] local_mac,
    input logic        promisc,
    input logic        accept_bcast,
    input logic        accept_mcast
  );
    logic is_bcast;
    is_bcast = (dest == BCAST_ADDR);
    return promisc
        || (dest == local_mac)
        || (is_bcast && accept_bcast)
        || (dest[MCAST_BIT] && accept_mcast && !is_bcast);
  endfunction

endpackage

// File: rtl/stream_reg_slice.sv
// One-entry registered valid/ready stage.
//   clk, rst             : clock, synchronous active-high reset
//   in_data/valid/ready  : upstream side
//   out_data/valid/ready : downstream side, fully registered
// Accepts a new word whenever empty or the held word is leaving, giving full
// throughput with 1-cycle latency. Output data is stable while stalled.
module stream_reg_slice #(
  parameter int unsigned W = 33
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);

  assign in_ready = !out_valid || out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (in_ready) begin
      out_valid <= in_valid;
      if (in_valid) begin
        out_data <= in_data;
      end
    end
  end

endmodule

// File: rtl/dest_mac_filter.sv
// Per-packet destination-address / length filter.
//   clk, rst                       : clock, synchronous active-high reset
//   s_data/valid/ready/last        : buffered upstream stream
//   s_dest_addr, s_length          : per-packet metadata (length is beats-1)
//   up_drop                        : one-cycle pulse, upstream flushes its packet
//   m_data/valid/ready/last        : forwarded stream (registered slice)
//   local_mac, promisc,
//   accept_bcast, accept_mcast     : filter configuration
//   clear_counters                 : clears cnt_pass / cnt_drop
//   cnt_pass, cnt_drop             : saturating packet statistics
module dest_mac_filter
  import filter_pkg::*;
#(
  parameter int unsigned STREAM_W  = 32,
  parameter int unsigned MIN_BEATS = 2,
  parameter int unsigned MAX_BEATS = 255,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [STREAM_W-1:0] s_data,
  input  logic                s_valid,
  output logic                s_ready,
  input  logic                s_last,
  input  logic [47:0]         s_dest_addr,
  input  logic [STREAM_W-1:0] s_length,
  output logic                up_drop,
  output logic [STREAM_W-1:0] m_data,
  output logic                m_valid,
  input  logic                m_ready,
  output logic                m_last,
  input  logic [47:0]         local_mac,
  input  logic                promisc,
  input  logic                accept_bcast,
  input  logic                accept_mcast,
  input  logic                clear_counters,
  output logic [CNT_W-1:0]    cnt_pass,
  output logic [CNT_W-1:0]    cnt_drop
);

  localparam logic [STREAM_W:0] MIN_B = (STREAM_W + 1)'(MIN_BEATS);
  localparam logic [STREAM_W:0] MAX_B = (STREAM_W + 1)'(MAX_BEATS);

  state_t              state;
  logic [47:0]         dest_q;
  logic [STREAM_W-1:0] len_q;
  logic                guard_q;

  logic [STREAM_W:0]   beats;
  logic                len_ok;
  logic                accept;
  logic                slice_in_ready;
  logic                slice_in_valid;
  logic                pass_done;

  // One extra bit so length-minus-one of all-ones cannot wrap to zero beats.
  assign beats  = {1'b0, len_q} + (STREAM_W + 1)'(1);
  assign len_ok = (beats >= MIN_B) && (beats <= MAX_B);
  assign accept = addr_match(dest_q, local_mac, promisc, accept_bcast, accept_mcast) && len_ok;

  assign slice_in_valid = (state == PASS) && s_valid;
  assign s_ready        = (state == PASS) && slice_in_ready;
  assign pass_done      = (state == PASS) && s_valid && slice_in_ready && s_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      dest_q  <= '0;
      len_q   <= '0;
      guard_q <= 1'b0;
      up_drop <= 1'b0;
    end else begin
      up_drop <= 1'b0;
      unique case (state)
        IDLE: begin
          // After a drop, upstream still shows the flushed packet for a cycle;
          // wait for s_valid to fall before latching new metadata.
          if (guard_q) begin
            if (!s_valid) begin
              guard_q <= 1'b0;
            end
          end else if (s_valid) begin
            dest_q <= s_dest_addr;
            len_q  <= s_length;
            state  <= EVAL;
          end
        end
        EVAL: begin
          if (accept) begin
            state <= PASS;
          end else begin
            state   <= DROP;
            up_drop <= 1'b1;
          end
        end
        PASS: begin
          if (pass_done) begin
            state <= IDLE;
          end
        end
        DROP: begin
          state   <= IDLE;
          guard_q <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clear_counters) begin
      cnt_pass <= '0;
      cnt_drop <= '0;
    end else begin
      if (pass_done && (cnt_pass != '1)) begin
        cnt_pass <= cnt_pass + CNT_W'(1);
      end
      if ((state == DROP) && (cnt_drop != '1)) begin
        cnt_drop <= cnt_drop + CNT_W'(1);
      end
    end
  end

  stream_reg_slice #(
    .W (STREAM_W + 1)
  ) u_out_slice (
    .clk       (clk),
    .rst       (rst),
    .in_data   ({s_last, s_data}),
    .in_valid  (slice_in_valid),
    .in_ready  (slice_in_ready),
    .out_data  ({m_last, m_data}),
    .out_valid (m_valid),
    .out_ready (m_ready)
  );

endmodule

// File: tb/tb_dest_mac_filter.sv
// Scoreboard bench for dest_mac_filter: the driver pushes expected beats/drops
// from a reference verdict, an independent monitor pops and compares.
module tb_dest_mac_filter;

  localparam int SW = 32;
  localparam int CW = 32;
  localparam logic [47:0] LOCAL = 48'h0200_0000_0001;
  localparam logic [47:0] OTHER = 48'h0200_0000_0002;
  localparam logic [47:0] BCAST = 48'hFFFF_FFFF_FFFF;
  localparam logic [47:0] MCAST = 48'h0100_5E00_0001;

  logic          clk = 1'b0;
  logic          rst;
  logic [SW-1:0] s_data;
  logic          s_valid;
  logic          s_ready;
  logic          s_last;
  logic [47:0]   s_dest_addr;
  logic [SW-1:0] s_length;
  logic          up_drop;
  logic [SW-1:0] m_data;
  logic          m_valid;
  logic          m_ready;
  logic          m_last;
  logic [47:0]   local_mac;
  logic          promisc;
  logic          accept_bcast;
  logic          accept_mcast;
  logic          clear_counters;
  logic [CW-1:0] cnt_pass;
  logic [CW-1:0] cnt_drop;

  always #5 clk = ~clk;

  dest_mac_filter #(
    .STREAM_W  (SW),
    .MIN_BEATS (2),
    .MAX_BEATS (255),
    .CNT_W     (CW)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .s_data         (s_data),
    .s_valid        (s_valid),
    .s_ready        (s_ready),
    .s_last         (s_last),
    .s_dest_addr    (s_dest_addr),
    .s_length       (s_length),
    .up_drop        (up_drop),
    .m_data         (m_data),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_last         (m_last),
    .local_mac      (local_mac),
    .promisc        (promisc),
    .accept_bcast   (accept_bcast),
    .accept_mcast   (accept_mcast),
    .clear_counters (clear_counters),
    .cnt_pass       (cnt_pass),
    .cnt_drop       (cnt_drop)
  );

  typedef struct packed {
    logic          last;
    logic [SW-1:0] data;
  } beat_t;

  beat_t beat_q[$];
  int    drop_q[$];
  int    cur_id      = 0;
  int    vectors     = 0;
  int    miscompares = 0;
  int    exp_pass    = 0;
  int    exp_drop    = 0;
  int    rdy_mode    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic note_fail(input string name, input string detail);
    vectors++;
    miscompares++;
    $display("FAIL %s %s", name, detail);
  endtask

  // Reference verdict straight from the filter rules.
  function automatic bit ref_accept(input logic [47:0] d, input logic [31:0] len);
    longint n;
    bit     all_ones;
    bit     hit;
    n        = longint'(len) + 1;
    all_ones = (d == BCAST);
    hit      = promisc || (d == local_mac) || (all_ones && accept_bcast)
            || (d[40] && accept_mcast && !all_ones);
    return hit && (n >= 2) && (n <= 255);
  endfunction

  // Downstream ready generator.
  initial begin
    int k;
    k = 0;
    m_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       m_ready = 1'b1;
        1:       m_ready = 1'($urandom_range(0, 1));
        default: begin
          m_ready = (k % 3 == 0);
          k++;
        end
      endcase
    end
  end

  // Monitor: compares every presented beat / drop pulse with the scoreboard.
  initial begin
    logic          stall;
    logic [SW-1:0] pd;
    logic          pl;
    beat_t         b;
    int            id;
    stall = 1'b0;
    pd    = '0;
    pl    = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("hold_valid", m_valid, 1);
          check("hold_data", m_data, pd);
          check("hold_last", m_last, pl);
        end
        if (m_valid && !m_ready) check("s_ready_when_full", s_ready, 0);
        if (m_valid && m_ready) begin
          if (beat_q.size() == 0) begin
            note_fail("unexpected_beat", $sformatf("actual=%0h required=none", m_data));
          end else begin
            b = beat_q.pop_front();
            check("beat_data", m_data, b.data);
            check("beat_last", m_last, b.last);
          end
        end
        if (up_drop) begin
          if (drop_q.size() == 0) begin
            note_fail("unexpected_drop", $sformatf("actual=pulse required=none pkt=%0d", cur_id));
          end else begin
            id = drop_q.pop_front();
            check("drop_pkt", cur_id, id);
          end
        end
        stall = m_valid && !m_ready;
        pd    = m_data;
        pl    = m_last;
      end
    end
  end

  task automatic check_reset_outputs();
    check("rst_s_ready", s_ready, 0);
    check("rst_up_drop", up_drop, 0);
    check("rst_m_valid", m_valid, 0);
    check("rst_m_last", m_last, 0);
    check("rst_m_data", m_data, 0);
    check("rst_cnt_pass", cnt_pass, 0);
    check("rst_cnt_drop", cnt_drop, 0);
  endtask

  // Upstream driver. abort_after>0 pulses rst after that many beats.
  task automatic send_pkt(input logic [47:0] dest, input logic [31:0] len,
                          input int abort_after, input bit clear_on_last);
    bit            acc;
    bit            aborted;
    int            nb;
    int            cyc;
    int            beat;
    bit            done;
    logic [SW-1:0] dat[$];
    acc     = ref_accept(dest, len);
    aborted = 1'b0;
    cur_id++;
    nb = acc ? int'(len) + 1 : 1;
    for (int i = 0; i < nb; i++) begin
      dat.push_back(SW'($urandom));
      if (acc) beat_q.push_back('{last: (i == nb - 1), data: dat[i]});
    end
    if (!acc) drop_q.push_back(cur_id);

    @(posedge clk);
    #1;
    s_valid     = 1'b1;
    s_dest_addr = dest;
    s_length    = len;
    s_data      = dat[0];
    s_last      = (len == 0);
    beat        = 0;
    cyc         = 0;
    done        = 1'b0;
    while (!done) begin
      @(negedge clk);
      cyc++;
      if (cyc > 3000) begin
        note_fail("timeout", $sformatf("pkt=%0d beat=%0d", cur_id, beat));
        s_valid = 1'b0;
        done    = 1'b1;
      end else begin
        if (beat == 0 && cyc <= 2) check("s_ready_early", s_ready, 0);
        if (up_drop) begin
          check("drop_latency", cyc - 1, 2);
          @(posedge clk);
          #1;
          s_valid = 1'b0;
          s_last  = 1'b0;
          done    = 1'b1;
        end else if (s_valid && s_ready) begin
          if (!acc) note_fail("unexpected_accept", $sformatf("pkt=%0d required=drop", cur_id));
          if (clear_on_last && beat == nb - 1) clear_counters = 1'b1;
          beat++;
          @(posedge clk);
          #1;
          clear_counters = 1'b0;
          if (abort_after != 0 && beat == abort_after) begin
            rst     = 1'b1;
            s_valid = 1'b0;
            s_last  = 1'b0;
            @(posedge clk);
            #1;
            rst = 1'b0;
            check_reset_outputs();
            beat_q.delete();
            aborted = 1'b1;
            done    = 1'b1;
          end else if (beat >= nb) begin
            s_valid = 1'b0;
            s_last  = 1'b0;
            done    = 1'b1;
          end else begin
            s_data = dat[beat];
            s_last = (beat == nb - 1);
          end
        end
      end
    end

    if (aborted || clear_on_last) begin
      exp_pass = 0;
      exp_drop = 0;
    end else if (acc) begin
      exp_pass++;
    end else begin
      exp_drop++;
    end
    check("cnt_pass", cnt_pass, exp_pass);
    check("cnt_drop", cnt_drop, exp_drop);
  endtask

  initial begin
    logic [47:0] d;
    logic [31:0] l;
    int          w;
    rst            = 1'b1;
    s_data         = '0;
    s_valid        = 1'b0;
    s_last         = 1'b0;
    s_dest_addr    = '0;
    s_length       = '0;
    local_mac      = LOCAL;
    promisc        = 1'b0;
    accept_bcast   = 1'b0;
    accept_mcast   = 1'b0;
    clear_counters = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs();
    rst = 1'b0;

    send_pkt(LOCAL, 32'd3, 0, 1'b0);
    send_pkt(OTHER, 32'd3, 0, 1'b0);
    send_pkt(BCAST, 32'd2, 0, 1'b0);
    accept_bcast = 1'b1;
    send_pkt(BCAST, 32'd2, 0, 1'b0);
    accept_mcast = 1'b1;
    send_pkt(MCAST, 32'd4, 0, 1'b0);
    send_pkt(LOCAL, 32'd0, 0, 1'b0);
    send_pkt(LOCAL, 32'd1, 0, 1'b0);
    promisc = 1'b1;
    send_pkt(OTHER, 32'd255, 0, 1'b0);
    send_pkt(OTHER, 32'd254, 0, 1'b0);
    promisc = 1'b0;

    rdy_mode = 2;
    send_pkt(LOCAL, 32'd7, 0, 1'b0);
    rdy_mode = 0;
    repeat (4) @(posedge clk);
    #1;
    send_pkt(LOCAL, 32'd5, 3, 1'b0);
    send_pkt(LOCAL, 32'd5, 0, 1'b0);
    send_pkt(LOCAL, 32'd3, 0, 1'b1);

    rdy_mode = 1;
    for (int p = 0; p < 40; p++) begin
      case ($urandom_range(0, 4))
        0:       d = LOCAL;
        1:       d = OTHER;
        2:       d = BCAST;
        3:       d = MCAST;
        default: d = {16'($urandom), 32'($urandom)};
      endcase
      w = int'($urandom_range(0, 9));
      if (w == 8)      l = 32'd254;
      else if (w == 9) l = 32'd255;
      else             l = 32'($urandom_range(0, 12));
      promisc      = ($urandom_range(0, 4) == 0);
      accept_bcast = 1'($urandom_range(0, 1));
      accept_mcast = 1'($urandom_range(0, 1));
      send_pkt(d, l, 0, 1'b0);
    end

    rdy_mode = 0;
    for (int c = 0; c < 500 && beat_q.size() != 0; c++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    check("drain_beats", beat_q.size(), 0);
    check("drain_drops", drop_q.size(), 0);
    check("idle_m_valid", m_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
